// File: rtl/urng_mix_if.sv
// Request, seed and result signals of the URNG table-update stage.
// The master drives requests, seeds and out_ready. The slave is the mix stage.
interface urng_mix_if #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32
);
  logic              seed_we;
  logic [ADDR_W-1:0] seed_addr;
  logic [DATA_W-1:0] seed_data;
  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] p_addr;
  logic [ADDR_W-1:0] q_addr;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] s_addr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [15:0]       out_count;
  logic              busy;

  modport master (
    output seed_we, seed_addr, seed_data, in_valid, p_addr, q_addr, r_addr,
           s_addr, out_ready,
    input  in_ready, out_valid, out_data, out_count, busy
  );

  modport slave (
    input  seed_we, seed_addr, seed_data, in_valid, p_addr, q_addr, r_addr,
           s_addr, out_ready,
    output in_ready, out_valid, out_data, out_count, busy
  );
endinterface

// File: rtl/urng_mix.sv
// URNG table-update stage. It computes T[s] = (T[p] ^ rotl(T[q],ROT)) + T[r].
// A single-port table is accessed one read or write per cycle.
module urng_mix #(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ROT    = 7
) (
  input  logic         clk,
  input  logic         rst,
  urng_mix_if.slave    bus
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {IDLE, RD_P, RD_Q, RD_R, CALC, WR, OUT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_data;
  logic [ADDR_W-1:0] p_q, q_q, r_q, s_q;
  logic [DATA_W-1:0] a_q, b_q, res_q, rot_b, mix;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic [15:0]       count_q;

  logic              mem_we_c;
  logic [ADDR_W-1:0] mem_addr_c;
  logic [DATA_W-1:0] mem_wdata_c;
  logic              accept_c, cap_a_c, cap_b_c, calc_c, load_out_c, done_c;
  logic              in_ready_c, busy_c;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.in_valid && !bus.seed_we) state_nxt = RD_P;
      RD_P:    state_nxt = RD_Q;
      RD_Q:    state_nxt = RD_R;
      RD_R:    state_nxt = CALC;
      CALC:    state_nxt = WR;
      WR:      state_nxt = OUT;
      OUT:     if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Table port steering and per-state strobes
  always_comb begin
    mem_we_c    = 1'b0;
    mem_addr_c  = p_q;
    mem_wdata_c = res_q;
    accept_c    = 1'b0;
    cap_a_c     = 1'b0;
    cap_b_c     = 1'b0;
    calc_c      = 1'b0;
    load_out_c  = 1'b0;
    done_c      = 1'b0;
    in_ready_c  = 1'b0;
    busy_c      = (state != IDLE);
    unique case (state)
      IDLE: begin
        in_ready_c  = !bus.seed_we;
        mem_we_c    = bus.seed_we;
        mem_addr_c  = bus.seed_addr;
        mem_wdata_c = bus.seed_data;
        accept_c    = bus.in_valid && !bus.seed_we;
      end
      RD_P: mem_addr_c = p_q;
      RD_Q: begin
        mem_addr_c = q_q;
        cap_a_c    = 1'b1;
      end
      RD_R: begin
        mem_addr_c = r_q;
        cap_b_c    = 1'b1;
      end
      CALC: calc_c = 1'b1;
      WR: begin
        mem_we_c   = 1'b1;
        mem_addr_c = s_q;
        load_out_c = 1'b1;
      end
      OUT:     done_c = bus.out_ready;
      default: ;
    endcase
  end

  // Reset blocks the write so an aborted request never updates T[s]
  always_ff @(posedge clk) begin
    if (mem_we_c && !rst) mem[mem_addr_c] <= mem_wdata_c;
    rd_data <= mem[mem_addr_c];
  end

  generate
    if (ROT == 0) begin : g_norot
      assign rot_b = b_q;
    end else begin : g_rot
      assign rot_b = {b_q[DATA_W-1-ROT:0], b_q[DATA_W-1:DATA_W-ROT]};
    end
  endgenerate

  // c is used straight from the read register in CALC
  assign mix = (a_q ^ rot_b) + rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      s_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      count_q     <= '0;
    end else begin
      if (accept_c) begin
        p_q <= bus.p_addr;
        q_q <= bus.q_addr;
        r_q <= bus.r_addr;
        s_q <= bus.s_addr;
      end
      if (cap_a_c) a_q   <= rd_data;
      if (cap_b_c) b_q   <= rd_data;
      if (calc_c)  res_q <= mix;
      if (load_out_c) begin
        out_data_q  <= res_q;
        out_valid_q <= 1'b1;
      end
      if (done_c) begin
        out_valid_q <= 1'b0;
        count_q     <= count_q + 16'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.busy      = busy_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_urng_mix.sv
// Bench for urng_mix. It uses directed cases and random requests.
// Results are compared against a word-array model of the table.
module tb_urng_mix;
  localparam int unsigned AW  = 10;
  localparam int unsigned DW  = 32;
  localparam int unsigned ROT = 7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  urng_mix_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  urng_mix #(.ADDR_W(AW), .DATA_W(DW), .ROT(ROT)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;
  int exp_count = 0;
  logic [DW-1:0] mdl [1 << AW];

  function automatic logic [DW-1:0] model_mix(int p, int q, int r);
    logic [2*DW-1:0] dbl;
    dbl = {mdl[q], mdl[q]} << ROT;
    return (mdl[p] ^ dbl[2*DW-1:DW]) + mdl[r];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic seed(input int a, input logic [DW-1:0] d);
    bus.seed_we   = 1'b1;
    bus.seed_addr = AW'(a);
    bus.seed_data = d;
    tick();
    bus.seed_we = 1'b0;
    mdl[a] = d;
  endtask

  // Starts one cycle after acceptance; follows the request through to IDLE
  task automatic finish_req(input int s, input logic [DW-1:0] expv, input int hold, input bit ghost);
    for (int k = 1; k <= 5; k++) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL latency cyc=%0d out_valid=%b busy=%b want 0/1", k, bus.out_valid, bus.busy);
      end
      if (ghost && k == 2) begin
        bus.seed_we   = 1'b1;
        bus.seed_addr = AW'($urandom_range(0, 15));
        bus.seed_data = $urandom;
      end
      if (k == 3) bus.seed_we = 1'b0;
      tick();
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== expv) begin
      failures++;
      $display("FAIL result out_valid=%b data=%h want 1/%h", bus.out_valid, bus.out_data, expv);
    end
    for (int h = 0; h < hold; h++) begin
      bus.out_ready = 1'b0;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== expv || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
        failures++;
        $display("FAIL hold v=%b d=%h rdy=%b busy=%b want 1/%h/0/1",
                 bus.out_valid, bus.out_data, bus.in_ready, bus.busy, expv);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    mdl[s] = expv;
    exp_count++;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 ||
        bus.out_count !== 16'(exp_count) || bus.out_data !== expv) begin
      failures++;
      $display("FAIL done v=%b busy=%b rdy=%b cnt=%0d d=%h want 0/0/1/%0d/%h",
               bus.out_valid, bus.busy, bus.in_ready, bus.out_count, bus.out_data,
               16'(exp_count), expv);
    end
  endtask

  task automatic run_req(input int p, input int q, input int r, input int s,
                         input logic [DW-1:0] expv, input int hold, input bit ghost);
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout in_ready=%b want 1", bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.p_addr = AW'(p);
    bus.q_addr = AW'(q);
    bus.r_addr = AW'(r);
    bus.s_addr = AW'(s);
    tick();
    bus.in_valid = 1'b0;
    finish_req(s, expv, hold, ghost);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.out_count !== 16'd0 ||
        bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset v=%b d=%h cnt=%0d busy=%b rdy=%b want 0/0/0/0/1",
               bus.out_valid, bus.out_data, bus.out_count, bus.busy, bus.in_ready);
    end
  endtask

  task automatic test_basic();
    seed(1, 32'h1); seed(2, 32'h100); seed(3, 32'h5);
    seed(6, 32'h0); seed(10, 32'h0);
    run_req(1, 2, 3, 4, 32'h0000_8006, 0, 1'b0);
    run_req(4, 10, 10, 20, 32'h0000_8006, 0, 1'b0);
  endtask

  task automatic test_alias();
    seed(1, 32'h1);
    run_req(1, 2, 3, 1, 32'h0000_8006, 0, 1'b0);
    run_req(1, 2, 3, 1, 32'h0000_000B, 1, 1'b0);
  endtask

  task automatic test_carry();
    seed(5, 32'hFFFF_FFFF); seed(6, 32'h0); seed(7, 32'h2);
    run_req(5, 6, 7, 8, 32'h0000_0001, 0, 1'b0);
  endtask

  task automatic test_backpressure();
    run_req(8, 10, 10, 21, 32'h0000_0001, 10, 1'b0);
  endtask

  task automatic test_seed_collision();
    bus.seed_we   = 1'b1;
    bus.seed_addr = AW'(12);
    bus.seed_data = 32'h1234_5678;
    bus.in_valid  = 1'b1;
    bus.p_addr = AW'(12);
    bus.q_addr = AW'(10);
    bus.r_addr = AW'(10);
    bus.s_addr = AW'(13);
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL collide_ready in_ready=%b want 0", bus.in_ready);
    end
    tick();
    bus.seed_we = 1'b0;
    mdl[12] = 32'h1234_5678;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL collide_wait busy=%b rdy=%b want 0/1", bus.busy, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    finish_req(13, 32'h1234_5678, 0, 1'b0);
  endtask

  task automatic test_random();
    int p, q, r, s;
    for (int a = 0; a < (1 << AW); a++) seed(a, $urandom);
    for (int i = 0; i < 40; i++) begin
      p = $urandom_range(0, 15);
      q = $urandom_range(0, 15);
      r = $urandom_range(0, 15);
      s = $urandom_range(0, 15);
      run_req(p, q, r, s, model_mix(p, q, r), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_in_wr();
    seed(9, 32'hAAAA_5555); seed(6, 32'h0); seed(10, 32'h0);
    bus.in_valid = 1'b1;
    bus.p_addr = AW'(6);
    bus.q_addr = AW'(10);
    bus.r_addr = AW'(10);
    bus.s_addr = AW'(9);
    tick();
    bus.in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_count !== 16'd0 || bus.busy !== 1'b0 || bus.out_data !== '0) begin
      failures++;
      $display("FAIL wr_reset v=%b cnt=%0d busy=%b d=%h want 0/0/0/0",
               bus.out_valid, bus.out_count, bus.busy, bus.out_data);
    end
    run_req(9, 10, 10, 11, 32'hAAAA_5555, 0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.seed_we = 1'b0;
    bus.seed_addr = '0;
    bus.seed_data = '0;
    bus.in_valid = 1'b0;
    bus.p_addr = '0;
    bus.q_addr = '0;
    bus.r_addr = '0;
    bus.s_addr = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_alias();
    test_carry();
    test_backpressure();
    test_seed_collision();
    test_random();
    test_reset_in_wr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
